// File: rtl/rib_arbiter.sv
// rtl/rib_arbiter.sv - Two-master RIB arbiter sharing one slave port between fetch (m0) and execute (m1).
// One transaction in flight at a time, one IDLE bubble between grants, bounded ex bursts and slave timeout.

module rib_arbiter #(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int ExBurstMax    = 4,
  parameter int TimeoutCycles = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,

  input  logic                 m0_req_i,
  input  logic [AddrWidth-1:0] m0_addr_i,
  output logic [DataWidth-1:0] m0_rdata_o,
  output logic                 m0_ready_o,

  input  logic                 m1_req_i,
  input  logic                 m1_we_i,
  input  logic [AddrWidth-1:0] m1_addr_i,
  input  logic [DataWidth-1:0] m1_wdata_i,
  output logic [DataWidth-1:0] m1_rdata_o,
  output logic                 m1_ready_o,

  output logic                 s_req_o,
  output logic                 s_we_o,
  output logic [AddrWidth-1:0] s_addr_o,
  output logic [DataWidth-1:0] s_wdata_o,
  input  logic [DataWidth-1:0] s_rdata_i,
  input  logic                 s_ready_i,

  output logic                 hold_flag_o,
  output logic                 timeout_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GNT_IF = 2'd1;
  localparam logic [1:0] GNT_EX = 2'd2;

  localparam logic [3:0] EX_MAX   = 4'(ExBurstMax);
  localparam logic [7:0] TMO_LAST = 8'(TimeoutCycles - 1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] ex_cnt;
  logic [3:0] ex_cnt_nxt;
  logic [7:0] tmo_cnt;
  logic       in_if;
  logic       in_ex;
  logic       granted;
  logic       tmo_hit;
  logic       done;

  assign in_if   = (state == GNT_IF);
  assign in_ex   = (state == GNT_EX);
  assign granted = in_if | in_ex;
  assign tmo_hit = granted & (tmo_cnt == TMO_LAST);
  assign done    = granted & (s_ready_i | tmo_hit);

  // ex_cnt only tracks m1 grants taken while m0 was kept waiting
  always_comb begin
    state_nxt  = state;
    ex_cnt_nxt = ex_cnt;
    case (state)
      IDLE: begin
        if (m1_req_i && (!m0_req_i || (ex_cnt < EX_MAX))) begin
          state_nxt = GNT_EX;
          if (!m0_req_i) begin
            ex_cnt_nxt = 4'd0;
          end else if (ex_cnt != 4'hF) begin
            ex_cnt_nxt = ex_cnt + 4'd1;
          end
        end else if (m0_req_i) begin
          state_nxt  = GNT_IF;
          ex_cnt_nxt = 4'd0;
        end else begin
          ex_cnt_nxt = 4'd0;
        end
      end
      GNT_IF, GNT_EX: begin
        if (s_ready_i || tmo_hit) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      ex_cnt  <= 4'd0;
      tmo_cnt <= 8'd0;
    end else begin
      state  <= state_nxt;
      ex_cnt <= ex_cnt_nxt;
      if (!granted || done) begin
        tmo_cnt <= 8'd0;
      end else begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    s_req_o    = granted;
    s_we_o     = 1'b0;
    s_addr_o   = '0;
    s_wdata_o  = '0;
    m0_ready_o = in_if & done;
    m1_ready_o = in_ex & done;
    m0_rdata_o = '0;
    m1_rdata_o = '0;
    if (in_if) begin
      s_addr_o = m0_addr_i;
    end else if (in_ex) begin
      s_we_o    = m1_we_i;
      s_addr_o  = m1_addr_i;
      s_wdata_o = m1_wdata_i;
    end
    // Real data wins over a coinciding timeout; a timed-out read returns zero
    if (in_if && s_ready_i) begin
      m0_rdata_o = s_rdata_i;
    end
    if (in_ex && s_ready_i) begin
      m1_rdata_o = s_rdata_i;
    end
  end

  assign timeout_o   = tmo_hit & ~s_ready_i;
  assign hold_flag_o = m1_req_i & (in_if | ((state == IDLE) & (state_nxt == GNT_IF)));

endmodule

// File: tb/tb_rib_arbiter.sv
// tb/tb_rib_arbiter.sv - Directed self-checking bench for rib_arbiter.

module tb_rib_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        m0_req_i;
  logic [31:0] m0_addr_i;
  logic [31:0] m0_rdata_o;
  logic        m0_ready_o;
  logic        m1_req_i;
  logic        m1_we_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_wdata_i;
  logic [31:0] m1_rdata_o;
  logic        m1_ready_o;
  logic        s_req_o;
  logic        s_we_o;
  logic [31:0] s_addr_o;
  logic [31:0] s_wdata_o;
  logic [31:0] s_rdata_i;
  logic        s_ready_i;
  logic        hold_flag_o;
  logic        timeout_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  rib_arbiter #(
    .AddrWidth(32), .DataWidth(32), .ExBurstMax(4), .TimeoutCycles(64)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_rdata_o(m0_rdata_o), .m0_ready_o(m0_ready_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_rdata_o(m1_rdata_o), .m1_ready_o(m1_ready_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_rdata_i(s_rdata_i), .s_ready_i(s_ready_i),
    .hold_flag_o(hold_flag_o), .timeout_o(timeout_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; m0_req_i = 1'b1; m0_addr_i = 32'h10; m1_req_i = 1'b1; m1_we_i = 1'b1;
    m1_addr_i = 32'h20; m1_wdata_i = 32'h30; s_rdata_i = 32'h40; s_ready_i = 1'b1;
    tick(); tick();
    tests++; if ({s_req_o, s_we_o, m0_ready_o, m1_ready_o, hold_flag_o, timeout_o} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl got %b want 000000", {s_req_o, s_we_o, m0_ready_o, m1_ready_o, hold_flag_o, timeout_o}); end
    tests++; if ({s_addr_o, s_wdata_o, m0_rdata_o, m1_rdata_o} !== 128'h0) begin
      fails++; $display("FAIL reset_data got %h want 0", {s_addr_o, s_wdata_o, m0_rdata_o, m1_rdata_o}); end
    m0_req_i = 1'b0; m1_req_i = 1'b0; m1_we_i = 1'b0; s_ready_i = 1'b0; s_rdata_i = '0;
    tick();
    rst_ni = 1'b1;
    tick();
    tests++; if (s_req_o !== 1'b0) begin fails++; $display("FAIL idle_after_reset got %b want 0", s_req_o); end
  endtask

  task automatic test_single_fetch();
    m0_req_i = 1'b1; m0_addr_i = 32'h100;
    #1;
    tests++; if (s_req_o !== 1'b0) begin fails++; $display("FAIL fetch_no_same_cycle got %b want 0", s_req_o); end
    tick();
    tests++; if ({s_req_o, s_we_o} !== 2'b10 || s_addr_o !== 32'h100) begin
      fails++; $display("FAIL fetch_grant got req/we %b addr %h want 10 100", {s_req_o, s_we_o}, s_addr_o); end
    s_ready_i = 1'b1; s_rdata_i = 32'h13;
    #1;
    tests++; if (m0_ready_o !== 1'b1 || m0_rdata_o !== 32'h13 || m1_ready_o !== 1'b0) begin
      fails++; $display("FAIL fetch_ready got %b/%h/%b want 1/13/0", m0_ready_o, m0_rdata_o, m1_ready_o); end
    tick();
    m0_req_i = 1'b0; s_ready_i = 1'b0;
    #1;
    tests++; if (s_req_o !== 1'b0 || m0_ready_o !== 1'b0) begin
      fails++; $display("FAIL fetch_idle got req %b ready %b want 0 0", s_req_o, m0_ready_o); end
  endtask

  task automatic test_simultaneous();
    m0_req_i = 1'b1; m0_addr_i = 32'h300;
    m1_req_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 32'h200; m1_wdata_i = 32'hCAFEF00D;
    #1;
    tests++; if (hold_flag_o !== 1'b0) begin fails++; $display("FAIL sim_hold_idle got %b want 0", hold_flag_o); end
    tick();
    tests++; if ({s_req_o, s_we_o, hold_flag_o} !== 3'b110 || s_addr_o !== 32'h200 || s_wdata_o !== 32'hCAFEF00D) begin
      fails++; $display("FAIL sim_ex_grant got %b %h %h want 110 200 cafef00d", {s_req_o, s_we_o, hold_flag_o}, s_addr_o, s_wdata_o); end
    s_ready_i = 1'b1; s_rdata_i = 32'h0;
    #1;
    tests++; if ({m0_ready_o, m1_ready_o} !== 2'b01) begin
      fails++; $display("FAIL sim_ex_ready got %b want 01", {m0_ready_o, m1_ready_o}); end
    tick();
    m1_req_i = 1'b0; m1_we_i = 1'b0; s_ready_i = 1'b0;
    #1;
    tests++; if (s_req_o !== 1'b0) begin fails++; $display("FAIL sim_bubble got %b want 0", s_req_o); end
    tick();
    tests++; if ({s_req_o, s_we_o} !== 2'b10 || s_addr_o !== 32'h300 || s_wdata_o !== 32'h0) begin
      fails++; $display("FAIL sim_if_grant got %b %h %h want 10 300 0", {s_req_o, s_we_o}, s_addr_o, s_wdata_o); end
    s_ready_i = 1'b1; s_rdata_i = 32'h77;
    #1;
    tests++; if (m0_ready_o !== 1'b1 || m0_rdata_o !== 32'h77) begin
      fails++; $display("FAIL sim_if_ready got %b %h want 1 77", m0_ready_o, m0_rdata_o); end
    tick();
    m0_req_i = 1'b0; s_ready_i = 1'b0;
    #1;
  endtask

  task automatic test_starvation();
    logic exp_if;
    m0_req_i = 1'b1; m0_addr_i = 32'h500;
    m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'h400;
    for (int g = 0; g < 6; g++) begin
      exp_if = (g == 4);
      #1;
      tests++; if (hold_flag_o !== exp_if) begin
        fails++; $display("FAIL starve_hold_idle[%0d] got %b want %b", g, hold_flag_o, exp_if); end
      tick();
      tests++; if (s_req_o !== 1'b1 || s_addr_o !== (exp_if ? 32'h500 : 32'h400) || hold_flag_o !== exp_if) begin
        fails++; $display("FAIL starve_grant[%0d] got req %b addr %h hold %b want if=%b", g, s_req_o, s_addr_o, hold_flag_o, exp_if); end
      s_ready_i = 1'b1; s_rdata_i = 32'h10 + 32'(g);
      #1;
      tests++; if (m0_ready_o !== exp_if || m1_ready_o !== !exp_if ||
                   (exp_if ? m0_rdata_o : m1_rdata_o) !== 32'h10 + 32'(g)) begin
        fails++; $display("FAIL starve_ready[%0d] got %b%b want %b%b", g, m0_ready_o, m1_ready_o, exp_if, !exp_if); end
      tick();
      s_ready_i = 1'b0;
    end
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    #1;
    tick();
  endtask

  task automatic test_timeout(input logic race);
    m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'h600; s_rdata_i = 32'hDEAD;
    tick();
    for (int c = 1; c < 64; c++) begin
      tests++; if (m1_ready_o !== 1'b0 || timeout_o !== 1'b0 || s_req_o !== 1'b1) begin
        fails++; $display("FAIL tmo_early[%0d] got ready %b tmo %b req %b want 0 0 1", c, m1_ready_o, timeout_o, s_req_o); end
      tick();
    end
    if (race) begin
      s_ready_i = 1'b1; s_rdata_i = 32'h55;
    end
    #1;
    tests++; if (m1_ready_o !== 1'b1 || m1_rdata_o !== (race ? 32'h55 : 32'h0) || timeout_o !== !race) begin
      fails++; $display("FAIL tmo_hit race=%b got %b %h %b want 1 %h %b", race, m1_ready_o, m1_rdata_o, timeout_o,
                        race ? 32'h55 : 32'h0, !race); end
    tick();
    m1_req_i = 1'b0; s_ready_i = 1'b0;
    #1;
    tests++; if (s_req_o !== 1'b0 || timeout_o !== 1'b0 || m1_ready_o !== 1'b0) begin
      fails++; $display("FAIL tmo_after got %b%b%b want 000", s_req_o, timeout_o, m1_ready_o); end
  endtask

  task automatic test_reset_mid();
    m1_req_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 32'h700; m1_wdata_i = 32'h1234;
    tick(); tick(); tick();
    m0_req_i = 1'b1; m0_addr_i = 32'h800;
    rst_ni = 1'b0; m1_req_i = 1'b0;
    #1;
    tests++; if ({s_req_o, s_we_o, m1_ready_o, timeout_o, hold_flag_o} !== 5'b0 || s_addr_o !== 32'h0 || s_wdata_o !== 32'h0) begin
      fails++; $display("FAIL rst_mid got %b %h %h want 00000 0 0", {s_req_o, s_we_o, m1_ready_o, timeout_o, hold_flag_o}, s_addr_o, s_wdata_o); end
    s_ready_i = 1'b1; s_rdata_i = 32'h99;
    #1;
    tests++; if (m1_ready_o !== 1'b0 || m0_ready_o !== 1'b0) begin
      fails++; $display("FAIL rst_no_ready got %b%b want 00", m0_ready_o, m1_ready_o); end
    tick();
    s_ready_i = 1'b0;
    rst_ni = 1'b1;
    #1;
    tests++; if (s_req_o !== 1'b0) begin fails++; $display("FAIL rst_release got %b want 0", s_req_o); end
    tick();
    tests++; if (s_req_o !== 1'b1 || s_addr_o !== 32'h800 || s_we_o !== 1'b0) begin
      fails++; $display("FAIL rst_regrant got %b %h %b want 1 800 0", s_req_o, s_addr_o, s_we_o); end
    s_ready_i = 1'b1; s_rdata_i = 32'hABC;
    #1;
    tests++; if (m0_ready_o !== 1'b1 || m0_rdata_o !== 32'hABC) begin
      fails++; $display("FAIL rst_regrant_ready got %b %h want 1 abc", m0_ready_o, m0_rdata_o); end
    tick();
    m0_req_i = 1'b0; s_ready_i = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
